// File: rtl/fir_coeff_loader_pkg.sv
// Shared constants and state encoding for the FIR coefficient loader.
// The filter RAM/FSM side uses the same constants, so the staging depth,
// word width and module count cannot drift apart.
package fir_coeff_loader_pkg;

    localparam int DATA_W      = 16;  // coefficient word width (filter RAM width)
    localparam int NUM_TAPS    = 10;  // coefficients per filter module
    localparam int NUM_MODULES = 4;   // filter MAC/RAM modules to load
    localparam int GAP_CYCLES  = 1;   // flag-low cycles between module bursts (>= 1)

    localparam int TAP_W = $clog2(NUM_TAPS);
    localparam int MOD_W = 2;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_BURST = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // True while a load is in flight (anything other than IDLE/DONE).
    function automatic logic is_loading(input state_t st);
        return (st == ST_FILL) || (st == ST_BURST) || (st == ST_GAP);
    endfunction

endpackage

// File: rtl/fir_coeff_loader_coeff_stage_buf.sv
// coeff_stage_buf: NUM_TAPS x DATA_W staging register file holding one
// module's worth of coefficients.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset, clears every entry to 0
//   wr_en    in   write strobe
//   wr_addr  in   write tap index
//   wr_data  in   write word
//   rd_addr  in   read tap index
//   rd_data  out  combinational read data (registered by the caller)
module coeff_stage_buf
    import fir_coeff_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [TAP_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAP_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [NUM_TAPS];

    // Storage array: cleared on reset, single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en && (wr_addr < TAP_W'(NUM_TAPS))) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Addresses beyond the array depth read as zero rather than aliasing.
    assign rd_data = (rd_addr < TAP_W'(NUM_TAPS)) ? mem_r[rd_addr] : '0;

endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: stages NUM_TAPS coefficient words from a valid/ready
// stream, then bursts them into the filter update port, one module at a
// time (0..NUM_MODULES-1), and finally switches the filter to run mode.
// Ports:
//   iClk12M          in   system clock, rising edge
//   iRsn             in   asynchronous active-low reset
//   iLoadStart       in   pulse: start a full load (ignored while busy)
//   iCoeffValid      in   source word valid
//   iCoeffData       in   source coefficient word
//   oCoeffReady      out  loader accepts a word this cycle
//   oCoeffUpdateFlag out  filter write strobe, one word per high cycle
//   oModuleSel       out  target module during a burst, holds otherwise
//   oWtDtRam         out  coefficient word to filter, 0 while strobe low
//   oMemRdFlag       out  filter run mode (coefficients valid)
//   oBusy            out  load in progress
//   oLoadDone        out  one-cycle pulse when the final burst completes
module fir_coeff_loader
    import fir_coeff_loader_pkg::*;
(
    input  logic              iClk12M,
    input  logic              iRsn,
    input  logic              iLoadStart,
    input  logic              iCoeffValid,
    input  logic [DATA_W-1:0] iCoeffData,
    output logic              oCoeffReady,
    output logic              oCoeffUpdateFlag,
    output logic [MOD_W-1:0]  oModuleSel,
    output logic [DATA_W-1:0] oWtDtRam,
    output logic              oMemRdFlag,
    output logic              oBusy,
    output logic              oLoadDone
);

    state_t             state_r, state_s;
    logic [TAP_W-1:0]   tap_r, tap_s;
    logic [MOD_W-1:0]   mod_r, mod_s;
    logic [GAP_W-1:0]   gap_r, gap_s;
    logic               wr_en_s;
    logic [DATA_W-1:0]  rd_data_s;

    logic               ready_r;
    logic               flag_r;
    logic [MOD_W-1:0]   sel_r;
    logic [DATA_W-1:0]  wdata_r;
    logic               memrd_r;
    logic               busy_r;
    logic               done_r;

    coeff_stage_buf u_stage_buf (
        .clk     (iClk12M),
        .rst_n   (iRsn),
        .wr_en   (wr_en_s),
        .wr_addr (tap_r),
        .wr_data (iCoeffData),
        .rd_addr (tap_r),
        .rd_data (rd_data_s)
    );

    // State and counter registers.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_r <= ST_IDLE;
            tap_r   <= '0;
            mod_r   <= '0;
            gap_r   <= '0;
        end else begin
            state_r <= state_s;
            tap_r   <= tap_s;
            mod_r   <= mod_s;
            gap_r   <= gap_s;
        end
    end

    // Next-state and counter logic. In FILL, ready is high exactly when the
    // state is FILL, so a valid word is accepted without looking at ready.
    always_comb begin
        state_s = state_r;
        tap_s   = tap_r;
        mod_s   = mod_r;
        gap_s   = gap_r;
        wr_en_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (iLoadStart) begin
                    state_s = ST_FILL;
                    tap_s   = '0;
                    mod_s   = '0;
                    gap_s   = '0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FILL: begin
                if (iCoeffValid) begin
                    wr_en_s = 1'b1;
                    if (tap_r == TAP_W'(NUM_TAPS - 1)) begin
                        tap_s   = '0;
                        state_s = ST_BURST;
                    end else begin
                        tap_s = tap_r + TAP_W'(1);
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_BURST: begin
                if (tap_r == TAP_W'(NUM_TAPS - 1)) begin
                    tap_s = '0;
                    if (mod_r == MOD_W'(NUM_MODULES - 1)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_GAP;
                        gap_s   = '0;
                    end
                end else begin
                    tap_s = tap_r + TAP_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_r == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_s   = '0;
                    mod_s   = mod_r + MOD_W'(1);
                    state_s = ST_FILL;
                end else begin
                    gap_s = gap_r + GAP_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                tap_s   = '0;
                mod_s   = '0;
                gap_s   = '0;
            end
        endcase
    end

    // Output registers. Status outputs follow the next state; the write
    // strobe/data trail the BURST state by one cycle so that data and
    // module select are stable for the whole flag-high cycle.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            ready_r <= 1'b0;
            flag_r  <= 1'b0;
            sel_r   <= '0;
            wdata_r <= '0;
            memrd_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_s == ST_FILL);
            busy_r  <= is_loading(state_s);
            memrd_r <= (state_s == ST_DONE);
            done_r  <= (state_r == ST_BURST) && (state_s == ST_DONE);
            flag_r  <= (state_r == ST_BURST);
            if (state_r == ST_BURST) begin
                wdata_r <= rd_data_s;
                sel_r   <= mod_r;
            end else begin
                wdata_r <= '0;
                sel_r   <= sel_r;
            end
        end
    end

    assign oCoeffReady      = ready_r;
    assign oCoeffUpdateFlag = flag_r;
    assign oModuleSel       = sel_r;
    assign oWtDtRam         = wdata_r;
    assign oMemRdFlag       = memrd_r;
    assign oBusy            = busy_r;
    assign oLoadDone        = done_r;

endmodule

// File: tb/tb_fir_coeff_loader.sv
module tb_fir_coeff_loader;

    localparam int NT  = 10;
    localparam int NM  = 4;
    localparam int NW  = NT * NM;

    logic        clk;
    logic        rsn;
    logic        load_start;
    logic        coeff_valid;
    logic [15:0] coeff_data;
    logic        coeff_ready;
    logic        upd_flag;
    logic [1:0]  module_sel;
    logic [15:0] wt_dt_ram;
    logic        mem_rd_flag;
    logic        busy;
    logic        load_done;

    fir_coeff_loader dut (
        .iClk12M          (clk),
        .iRsn             (rsn),
        .iLoadStart       (load_start),
        .iCoeffValid      (coeff_valid),
        .iCoeffData       (coeff_data),
        .oCoeffReady      (coeff_ready),
        .oCoeffUpdateFlag (upd_flag),
        .oModuleSel       (module_sel),
        .oWtDtRam         (wt_dt_ram),
        .oMemRdFlag       (mem_rd_flag),
        .oBusy            (busy),
        .oLoadDone        (load_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation log filled by the monitor, read by the stimulus.
    logic [17:0] wr_q[$];
    int          burst_q[$];
    int          rise_q[$];
    int          run_len = 0;
    int          done_cnt = 0;
    int          idle_data_err = 0;
    int          overlap_err = 0;

    always @(negedge clk) begin
        if (upd_flag) begin
            wr_q.push_back({module_sel, wt_dt_ram});
            if (run_len == 0) rise_q.push_back(cyc);
            run_len <= run_len + 1;
        end else begin
            if (run_len > 0) burst_q.push_back(run_len);
            run_len <= 0;
            if (wt_dt_ram !== 16'h0000) idle_data_err <= idle_data_err + 1;
        end
        if (upd_flag && coeff_ready) overlap_err <= overlap_err + 1;
        if (load_done) done_cnt <= done_cnt + 1;
    end

    int total = 0;
    int bad   = 0;
    logic [15:0] src_w [NW];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Run one load: stream src_w with optional stalls/start pokes and compare
    // the observed filter writes against the expected module/tap ordering.
    task automatic run_load(input string name, input int stall_pct, input bit fixed_stall,
                            input bit poke, input int abort_at, output int done_cyc,
                            output bit aborted);
        int  k = 0;
        int  t = 0;
        int  stall_left = 0;
        bit  stall_done = 1'b0;
        bit  seen = 1'b0;
        bit  rdy;
        int  extra = 0;
        int  acc10 = -1;
        int  start_cyc;
        int  wb = wr_q.size();
        int  bb = burst_q.size();
        int  rb = rise_q.size();
        int  db = done_cnt;
        logic [1:0] m;
        done_cyc = -1;
        aborted  = 1'b0;

        load_start = 1'b1;
        @(posedge clk); #1;
        start_cyc  = cyc;
        load_start = 1'b0;
        chk({name, "_start_memrd"}, mem_rd_flag, 1'b0);
        chk({name, "_start_busy"}, busy, 1'b1);

        while (!seen && !aborted && t < 3000) begin
            coeff_valid = 1'b0;
            coeff_data  = 16'h0000;
            load_start  = 1'b0;
            if (k < NW) begin
                if (fixed_stall && k == 4 && !stall_done) begin
                    stall_left = 5;
                    stall_done = 1'b1;
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else if ($urandom_range(0, 99) >= stall_pct) begin
                    coeff_valid = 1'b1;
                    coeff_data  = src_w[k];
                end
            end else begin
                coeff_valid = 1'($urandom_range(0, 1));
                coeff_data  = 16'($urandom);
            end
            if (poke && busy && $urandom_range(0, 3) == 0) load_start = 1'b1;
            rdy = coeff_ready;
            @(posedge clk); #1;
            if (coeff_valid && rdy) begin
                if (k < NW) begin
                    k++;
                    if (k == NT) acc10 = cyc;
                end else begin
                    extra++;
                end
            end
            if (load_done) begin
                seen     = 1'b1;
                done_cyc = cyc - start_cyc;
            end
            if (abort_at > 0 && (wr_q.size() - wb) == abort_at) aborted = 1'b1;
            t++;
        end
        coeff_valid = 1'b0;
        load_start  = 1'b0;

        if (!aborted) begin
            chk({name, "_done_seen"}, seen, 1'b1);
            chk({name, "_words_taken"}, k, NW);
            chk({name, "_extra_accept"}, extra, 0);
            repeat (3) @(posedge clk);
            #1;
            chk({name, "_wr_count"}, wr_q.size() - wb, NW);
            for (int i = 0; i < NW; i++) begin
                m = 2'(i / NT);
                if (wb + i < wr_q.size())
                    chk({name, "_wr"}, wr_q[wb + i], {m, src_w[i]});
            end
            chk({name, "_burst_count"}, burst_q.size() - bb, NM);
            for (int b = 0; b < NM; b++) begin
                if (bb + b < burst_q.size())
                    chk({name, "_burst_len"}, burst_q[bb + b], NT);
            end
            if (rb < rise_q.size())
                chk({name, "_first_flag_latency"}, rise_q[rb], acc10 + 1);
            else
                chk({name, "_first_flag_seen"}, 1'b0, 1'b1);
            chk({name, "_done_pulses"}, done_cnt - db, 1);
            chk({name, "_memrd_end"}, mem_rd_flag, 1'b1);
            chk({name, "_busy_end"}, busy, 1'b0);
            chk({name, "_ready_end"}, coeff_ready, 1'b0);
        end
    endtask

    int  dcyc;
    bit  ab;

    initial begin
        rsn         = 1'b0;
        load_start  = 1'b0;
        coeff_valid = 1'b0;
        coeff_data  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", coeff_ready, 1'b0);
        chk("rst_flag", upd_flag, 1'b0);
        chk("rst_sel", module_sel, 2'd0);
        chk("rst_data", wt_dt_ram, 16'h0000);
        chk("rst_memrd", mem_rd_flag, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", load_done, 1'b0);
        rsn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of module 2's burst, at tap 5.
        for (int i = 0; i < NW; i++) src_w[i] = 16'(16'h1000 + i);
        run_load("abort", 0, 1'b0, 1'b0, 25, dcyc, ab);
        chk("abort_reached", ab, 1'b1);
        chk("abort_sel", module_sel, 2'd2);
        chk("abort_flag", upd_flag, 1'b1);
        chk("abort_data", wt_dt_ram, 16'h1019);
        rsn = 1'b0;
        #1;
        chk("arst_ready", coeff_ready, 1'b0);
        chk("arst_flag", upd_flag, 1'b0);
        chk("arst_sel", module_sel, 2'd0);
        chk("arst_data", wt_dt_ram, 16'h0000);
        chk("arst_memrd", mem_rd_flag, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", load_done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rsn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_ready", coeff_ready, 1'b0);
        chk("post_rst_memrd", mem_rd_flag, 1'b0);

        // Full load without stalls, ramp data 0..39, minimum timing.
        for (int i = 0; i < NW; i++) src_w[i] = 16'(i);
        run_load("ramp", 0, 1'b0, 1'b0, 0, dcyc, ab);
        chk("ramp_done_cycle", dcyc, 83);

        // Five-cycle stall after word 3, random data.
        for (int i = 0; i < NW; i++) src_w[i] = 16'($urandom);
        run_load("stall", 0, 1'b1, 1'b0, 0, dcyc, ab);

        // Random stalls with iLoadStart pokes while busy.
        for (int i = 0; i < NW; i++) src_w[i] = 16'($urandom);
        run_load("poke", 30, 1'b0, 1'b1, 0, dcyc, ab);

        // Reload from DONE with all-ones (negative) coefficients.
        for (int i = 0; i < NW; i++) src_w[i] = 16'hFFFF;
        chk("reload_pre_memrd", mem_rd_flag, 1'b1);
        run_load("neg", 10, 1'b0, 1'b0, 0, dcyc, ab);

        chk("idle_data_zero", idle_data_err, 0);
        chk("ready_flag_overlap", overlap_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
